// File: rtl/mem_bus_unit.sv
// CPU-side memory/IO bus stage: steers CPU commands to the synchronous RAM, the LED
// register or the switch port, and signals completion over a 4-phase ready handshake.
module mem_bus_unit #(
   parameter int unsigned RAM_AW   = 8,
   parameter int unsigned DW       = 16,
   parameter logic [8:0]  LED_ADDR = 9'h100,
   parameter logic [8:0]  SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic [8:0]        mem_addr,
   input  logic [DW-1:0]     write_data,
   output logic [DW-1:0]     read_data,
   output logic              mem_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_din,
   output logic              ram_write,
   input  logic [DW-1:0]     ram_dout,
   input  logic [7:0]        SW,
   output logic [7:0]        LEDR,
   output logic              bus_err
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [DW-1:0]     read_data_q, read_data_d;
   logic              mem_ready_q, mem_ready_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0]     ram_din_q, ram_din_d;
   logic              ram_write_q, ram_write_d;
   logic [7:0]        ledr_q, ledr_d;
   logic              bus_err_q, bus_err_d;

   logic is_rd, is_wr;

   assign is_rd = (mem_cmd == 2'b01);
   assign is_wr = (mem_cmd == 2'b10);

   always_comb begin
      state_d     = state_q;
      read_data_d = read_data_q;
      mem_ready_d = mem_ready_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      ram_write_d = 1'b0;
      ledr_d      = ledr_q;
      bus_err_d   = bus_err_q;

      case (state_q)
         IDLE: begin
            if (is_rd || is_wr) begin
               // The accepted address/data are held in ram_addr_q/ram_din_q, so later
               // input changes cannot disturb an in-flight RAM access.
               if (!mem_addr[8]) begin
                  ram_addr_d = mem_addr[RAM_AW-1:0];
                  if (is_rd) begin
                     state_d = RD_ADDR;
                  end else begin
                     state_d     = WR;
                     ram_din_d   = write_data;
                     ram_write_d = 1'b1;
                  end
               end else begin
                  state_d     = DONE;
                  mem_ready_d = 1'b1;
                  if (is_rd && (mem_addr == SW_ADDR)) begin
                     read_data_d = {{(DW-8){1'b0}}, SW};
                  end else if (is_wr && (mem_addr == LED_ADDR)) begin
                     ledr_d = write_data[7:0];
                  end else begin
                     bus_err_d = 1'b1;
                     if (is_rd) begin
                        read_data_d = '0;
                     end
                  end
               end
            end else if (mem_cmd == 2'b11) begin
               bus_err_d = 1'b1;
            end
         end
         RD_ADDR: begin
            state_d = RD_DATA;
         end
         RD_DATA: begin
            state_d     = DONE;
            read_data_d = ram_dout;
            mem_ready_d = 1'b1;
         end
         WR: begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
         end
         DONE: begin
            if (mem_cmd == 2'b00) begin
               state_d     = IDLE;
               mem_ready_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         read_data_q <= '0;
         mem_ready_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         ram_write_q <= 1'b0;
         ledr_q      <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
         mem_ready_q <= mem_ready_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         ram_write_q <= ram_write_d;
         ledr_q      <= ledr_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign read_data = read_data_q;
   assign mem_ready = mem_ready_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign ram_write = ram_write_q;
   assign LEDR      = ledr_q;
   assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_bus_unit.md
Name: mem_bus_unit

Overview:
- Memory/IO bus stage directly downstream of the CPU's fetch/load/store path.
- Accepts CPU memory commands and steers them to the 256-word synchronous RAM or to memory-mapped I/O: LED register and switch port.
- Returns read data and completion to the CPU over a 4-phase ready handshake.
- Lets the CPU FSM wait on completion instead of hard-coding RAM latency.

Parameters:
- RAM_AW, 8, RAM word-address width (256 words)
- DW, 16, data word width
- LED_ADDR, 9'h100, write-only LED register address
- SW_ADDR, 9'h140, read-only switch port address

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_cmd  in  2  00 none, 01 read, 10 write, 11 illegal
- mem_addr  in  9  word address from CPU
- write_data  in  DW  store data from CPU
- read_data  out  DW  registered load/fetch data to CPU
- mem_ready  out  1  transaction complete, registered
- ram_addr  out  RAM_AW  RAM address
- ram_din  out  DW  RAM write data
- ram_write  out  1  RAM write enable, one-cycle pulse
- ram_dout  in  DW  RAM read data, valid one edge after ram_addr is sampled
- SW  in  8  switch inputs
- LEDR  out  8  LED register
- bus_err  out  1  sticky unmapped/illegal-access flag

Behaviour:
- Reset asserted (reset=0, asynchronous):
  - state=IDLE.
  - read_data=0, mem_ready=0, ram_write=0, ram_addr=0, ram_din=0, LEDR=0, bus_err=0.
  - Applies mid-transaction too: any in-flight write pulse is killed; the LED write is lost if the accept edge has not happened.
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE.
- IDLE:
  - mem_cmd=00: stay.
  - mem_cmd=01/10 on an edge: latch addr_q=mem_addr and data_q=write_data (accept edge).
  - Later changes to mem_cmd/mem_addr/write_data are ignored until back in IDLE.
- Read, addr_q[8]=0 (RAM):
  - accept -> RD_ADDR, with ram_addr=addr_q[7:0].
  - RD_ADDR -> RD_DATA; RAM samples the address on this edge.
  - RD_DATA -> DONE, with read_data<=ram_dout on this edge.
  - mem_ready rises 3 edges after accept.
- Read, addr_q==SW_ADDR: accept -> DONE; read_data<={8'b0,SW} on the accept edge. mem_ready rises 1 edge after accept.
- Write, addr_q[8]=0 (RAM):
  - accept -> WR.
  - In WR: ram_write=1, ram_addr=addr_q[7:0], ram_din=data_q for exactly one cycle.
  - WR -> DONE.
- Write, addr_q==LED_ADDR: accept -> DONE; LEDR<=data_q[7:0] on the accept edge.
- Unmapped (addr[8]=1, not LED/SW, or wrong direction such as a write to SW_ADDR or a read from LED_ADDR):
  - accept -> DONE; bus_err<=1.
  - A read returns read_data=0. A write has no side effect.
- mem_cmd=11 in IDLE: not accepted; bus_err<=1; stay in IDLE.
- DONE:
  - mem_ready=1; stays while mem_cmd!=00.
  - mem_cmd=00 -> IDLE; mem_ready=0 on that edge.
  - Back-to-back transactions therefore always have at least one IDLE cycle.
- read_data holds its last value until the next completed read; writes never modify it.
- ram_write is 0 in every state except WR.
- ram_addr and ram_din hold their last values outside WR and RD_*.
- bus_err is cleared only by reset.

Test Plan:
- Reset 0 then 1, then read 0x000 with ram mem[0]=16'hD004 -> mem_ready rises exactly 3 clocks after accept; read_data=16'hD004; ram_write never asserted.
- Write 0x004 with write_data=16'h0005, then drop cmd after mem_ready -> single-cycle ram_write with ram_addr=4, ram_din=5; read back 0x004 returns 16'h0005.
- Write 0x100 data 16'h00A5 -> LEDR=8'hA5 one edge after accept. Then SW=8'h3C, read 0x140 -> read_data=16'h003C, mem_ready after 1 edge.
- Read 0x1FF -> read_data=0, bus_err=1, mem_ready=1. Follow with a valid RAM read -> succeeds; bus_err stays 1.
- Hold mem_cmd=01 after mem_ready for 4 cycles -> mem_ready stays 1 and no new transaction starts. Change mem_addr during RD_ADDR -> result still from the originally latched address.
- Assert reset during WR -> ram_write drops to 0 immediately; LEDR=0, mem_ready=0, state IDLE; the next read completes normally.
